dcmi_ram_wr_sink: RTL and testbench

- Downstream stage of dcmi_top on the ram_clk side; it consumes the ram_wr_req / ram_wr_ack / ram_waddr / ram_wdata write stream.
- Buffers accepted words in a small FIFO and drains them into a single-port synchronous SRAM with programmable wait states.
- Arbitrates a system read port against the drain and keeps a committed-word counter plus a sticky out-of-range error flag.

---
 rtl/dcmi_ram_wr_sink.sv | 159 +++++++++++++++
 tb/tb_dcmi_ram_wr_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmi_ram_wr_sink.sv
// dcmi_ram_wr_sink
//   Consumes the ram_clk-side write stream from dcmi_top, buffers accepted
//   words in a small FIFO and drains them into a single-port synchronous SRAM
//   with WAIT_CYC extra cycles per access. A system read port shares the SRAM
//   and wins over the drain unless the FIFO is full. Reads may overtake
//   buffered writes; there is no forwarding.
//
// Ports
//   ram_clk, rst                   clock, synchronous active-high reset
//   ram_wr_req/ack, ram_waddr/wdata write stream in (ack = FIFO not full)
//   rd_req/addr, rd_ack            system read request / accept pulse
//   rd_valid, rd_data              read return (WAIT_CYC+2 cycles after rd_ack)
//   sram_cs/we/addr/wdata/rdata    single-port SRAM bus
//   cnt_clr, wr_cnt, addr_err      commit counter and sticky range error
//   fifo_lvl                       current FIFO occupancy

module dcmi_ram_wr_sink #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          WAIT_CYC   = 1,
    parameter logic [19:0] ADDR_LIMIT = 20'h40000
) (
    input  logic        ram_clk,
    input  logic        rst,
    input  logic        ram_wr_req,
    output logic        ram_wr_ack,
    input  logic [19:0] ram_waddr,
    input  logic [31:0] ram_wdata,
    input  logic        rd_req,
    input  logic [19:0] rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        cnt_clr,
    output logic [19:0] wr_cnt,
    output logic        addr_err,
    output logic [2:0]  fifo_lvl
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;

    state_t          state, state_n;
    logic [2:0]      wcnt;
    logic            last;
    logic            pop, rd_go, commit;
    logic [19:0]     acc_addr;
    logic [31:0]     acc_data;

    // ---------------- write buffer ----------------
    logic [51:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   lvl;
    logic            full, empty;
    logic            accept, in_range, push;

    assign full     = (lvl == CW'(FIFO_DEPTH));
    assign empty    = (lvl == '0);
    // Held low during reset so nothing is accepted while state is being cleared.
    assign ram_wr_ack = !full && !rst;
    assign accept   = ram_wr_req && ram_wr_ack;
    assign in_range = (ram_waddr < ADDR_LIMIT);
    assign push     = accept && in_range;
    assign fifo_lvl = 3'(lvl);

    always_ff @(posedge ram_clk) begin
        if (push)
            fifo_mem[wptr] <= {ram_waddr, ram_wdata};
    end

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            lvl <= lvl + CW'(push) - CW'(pop);
        end
    end

    // ---------------- access FSM ----------------
    assign last   = (wcnt == 3'(WAIT_CYC));
    assign commit = (state == WR) && last;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        rd_go   = 1'b0;
        unique case (state)
            IDLE: begin
                // A full FIFO forces a drain before any read is granted.
                if (rd_req && !full) begin
                    state_n = RD;
                    rd_go   = 1'b1;
                end else if (!empty) begin
                    state_n = WR;
                    pop     = 1'b1;
                end
            end
            WR:      if (last) state_n = IDLE;
            RD:      if (last) state_n = RWAIT;
            RWAIT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign sram_cs    = (state == WR) || (state == RD);
    assign sram_we    = (state == WR);
    assign sram_addr  = acc_addr;
    assign sram_wdata = acc_data;

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            acc_addr <= '0;
            acc_data <= '0;
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            wr_cnt   <= '0;
            addr_err <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= ((state == WR || state == RD) && !last) ? wcnt + 3'd1 : 3'd0;

            // Address/data are latched once so the bus is stable for the access.
            if (pop) begin
                acc_addr <= fifo_mem[rptr][51:32];
                acc_data <= fifo_mem[rptr][31:0];
            end else if (rd_go) begin
                acc_addr <= rd_addr;
            end

            // rd_ack lands in the first access cycle; rd_valid follows the
            // RWAIT capture, giving WAIT_CYC+2 cycles between them.
            rd_ack   <= rd_go;
            rd_valid <= (state == RWAIT);
            if (state == RWAIT)
                rd_data <= sram_rdata;

            if (cnt_clr)     wr_cnt <= '0;
            else if (commit) wr_cnt <= wr_cnt + 20'd1;

            // Setting beats clearing on a coincident out-of-range accept.
            if (accept && !in_range) addr_err <= 1'b1;
            else if (cnt_clr)        addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcmi_ram_wr_sink.sv
// Directed bench for dcmi_ram_wr_sink (FIFO_DEPTH=4, WAIT_CYC=1) with a
// behavioural SRAM and a write-access logger.

module tb_dcmi_ram_wr_sink;

    logic        ram_clk = 1'b0;
    logic        rst;
    logic        ram_wr_req;
    logic        ram_wr_ack;
    logic [19:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        sram_cs;
    logic        sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        cnt_clr;
    logic [19:0] wr_cnt;
    logic        addr_err;
    logic [2:0]  fifo_lvl;

    int checks = 0;
    int errors = 0;

    always #5 ram_clk = ~ram_clk;

    dcmi_ram_wr_sink #(.FIFO_DEPTH(4), .WAIT_CYC(1), .ADDR_LIMIT(20'h40000)) dut (
        .ram_clk(ram_clk), .rst(rst),
        .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .cnt_clr(cnt_clr), .wr_cnt(wr_cnt), .addr_err(addr_err),
        .fifo_lvl(fifo_lvl)
    );

    // SRAM model: read data appears the cycle after the last read cycle.
    logic [31:0] mem [256];
    logic [31:0] rdata_q = '0;
    logic        prev_wr = 1'b0;
    int          cur_len = 0;
    logic [19:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlen [$];

    assign sram_rdata = rdata_q;

    always @(posedge ram_clk) begin
        if (sram_cs && !sram_we) rdata_q <= mem[sram_addr[7:0]];
        if (sram_cs && sram_we) begin
            mem[sram_addr[7:0]] <= sram_wdata;
            if (!prev_wr) begin
                wlog_addr.push_back(sram_addr);
                wlog_data.push_back(sram_wdata);
                cur_len = 1;
            end else begin
                cur_len = cur_len + 1;
            end
        end else if (prev_wr) begin
            wlen.push_back(cur_len);
        end
        prev_wr <= sram_cs && sram_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge ram_clk);
        #1;
    endtask

    initial begin
        int i, b, first_low, maxl, n0, n1, ns, nr, bad;
        logic acked;

        rst = 1'b1; ram_wr_req = 1'b0; ram_waddr = '0; ram_wdata = '0;
        rd_req = 1'b0; rd_addr = '0; cnt_clr = 1'b0;
        repeat (3) @(posedge ram_clk);
        #1;

        // ---- reset state ----
        chk("rst_wr_ack",  32'(ram_wr_ack), 0);
        chk("rst_rd_ack",  32'(rd_ack), 0);
        chk("rst_rd_valid",32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cs",      32'(sram_cs), 0);
        chk("rst_we",      32'(sram_we), 0);
        chk("rst_addr",    32'(sram_addr), 0);
        chk("rst_wdata",   sram_wdata, 0);
        chk("rst_wr_cnt",  32'(wr_cnt), 0);
        chk("rst_addr_err",32'(addr_err), 0);
        chk("rst_lvl",     32'(fifo_lvl), 0);
        rst = 1'b0;
        cyc1();
        chk("idle_ack", 32'(ram_wr_ack), 1);

        // ---- single write ----
        ram_wr_req = 1'b1; ram_waddr = 20'd5; ram_wdata = 32'hA5A5_0001;
        #1;
        chk("t1_ack", 32'(ram_wr_ack), 1);
        cyc1(); ram_wr_req = 1'b0;
        chk("t1_lvl1", 32'(fifo_lvl), 1);
        chk("t1_cs_pre", 32'(sram_cs), 0);
        cyc1();
        chk("t1_cs_a", 32'(sram_cs), 1);
        chk("t1_we_a", 32'(sram_we), 1);
        chk("t1_addr", 32'(sram_addr), 5);
        chk("t1_wdata", sram_wdata, 32'hA5A5_0001);
        cyc1();
        chk("t1_cs_b", 32'(sram_cs), 1);
        cyc1();
        chk("t1_cs_end", 32'(sram_cs), 0);
        chk("t1_wr_cnt", 32'(wr_cnt), 1);
        chk("t1_lvl0", 32'(fifo_lvl), 0);

        // ---- burst of 10 ----
        cnt_clr = 1'b1; cyc1(); cnt_clr = 1'b0;
        chk("clr_wr_cnt", 32'(wr_cnt), 0);
        n0 = wlog_addr.size();
        i = 0; b = 0; first_low = -1; maxl = 0;
        while (i < 10 && b < 200) begin
            ram_wr_req = 1'b1; ram_waddr = 20'(i); ram_wdata = 32'h1000_0000 + 32'(i);
            #1;
            acked = ram_wr_ack;
            if (!acked && first_low < 0) first_low = i;
            if (int'(fifo_lvl) > maxl) maxl = int'(fifo_lvl);
            cyc1();
            if (acked) i++;
            b++;
        end
        ram_wr_req = 1'b0;
        chk("t2_accepts", 32'(i), 10);
        // Draining overlaps filling: one pop per 3 cycles vs one push per cycle.
        chk("t2_first_low", 32'(first_low), 6);
        b = 0;
        while (wr_cnt != 20'd10 && b < 100) begin
            if (int'(fifo_lvl) > maxl) maxl = int'(fifo_lvl);
            cyc1(); b++;
        end
        chk("t2_wr_cnt", 32'(wr_cnt), 10);
        chk("t2_max_lvl", 32'(maxl), 4);
        cyc1(); cyc1();
        chk("t2_lvl0", 32'(fifo_lvl), 0);
        chk("t2_log_n", 32'(wlog_addr.size() - n0), 10);
        if (wlog_addr.size() - n0 == 10) begin
            for (int k = 0; k < 10; k++) begin
                chk("t2_order_addr", 32'(wlog_addr[n0+k]), 32'(k));
                chk("t2_order_data", wlog_data[n0+k], 32'h1000_0000 + 32'(k));
            end
        end
        bad = 0;
        foreach (wlen[k]) if (wlen[k] != 2) bad++;
        chk("t2_access_len", 32'(bad), 0);

        // ---- out-of-range write ----
        ram_wr_req = 1'b1; ram_waddr = 20'h40000; ram_wdata = 32'hBAD0_0000;
        #1;
        chk("t3_ack", 32'(ram_wr_ack), 1);
        cyc1(); ram_wr_req = 1'b0;
        chk("t3_addr_err", 32'(addr_err), 1);
        chk("t3_lvl", 32'(fifo_lvl), 0);
        n1 = wlog_addr.size();
        repeat (4) cyc1();
        chk("t3_no_access", 32'(wlog_addr.size() - n1), 0);
        chk("t3_wr_cnt", 32'(wr_cnt), 10);

        // last in-range address
        ram_wr_req = 1'b1; ram_waddr = 20'h3FFFF; ram_wdata = 32'h3FFF_F000;
        cyc1(); ram_wr_req = 1'b0;
        b = 0;
        while (wr_cnt != 20'd11 && b < 20) begin cyc1(); b++; end
        chk("t3_edge_cnt", 32'(wr_cnt), 11);
        chk("t3_edge_addr", 32'(wlog_addr[wlog_addr.size()-1]), 32'h3FFFF);
        chk("t3_err_sticky", 32'(addr_err), 1);

        cnt_clr = 1'b1; cyc1(); cnt_clr = 1'b0;
        chk("t3_clr_err", 32'(addr_err), 0);
        chk("t3_clr_cnt", 32'(wr_cnt), 0);

        // clear coinciding with out-of-range accept: set wins
        cnt_clr = 1'b1; ram_wr_req = 1'b1; ram_waddr = 20'h7FFFF;
        cyc1(); cnt_clr = 1'b0; ram_wr_req = 1'b0;
        chk("t3_set_wins", 32'(addr_err), 1);
        cnt_clr = 1'b1; cyc1(); cnt_clr = 1'b0;
        chk("t3_clr_again", 32'(addr_err), 0);

        // ---- read with FIFO empty ----
        ram_wr_req = 1'b1; ram_waddr = 20'd3; ram_wdata = 32'hDEAD_BEEF;
        cyc1(); ram_wr_req = 1'b0;
        b = 0;
        while (wr_cnt != 20'd1 && b < 20) begin cyc1(); b++; end
        chk("t4_preload", 32'(wr_cnt), 1);
        cyc1();
        rd_req = 1'b1; rd_addr = 20'd3;
        cyc1();
        chk("t4_rd_ack", 32'(rd_ack), 1);
        chk("t4_cs", 32'(sram_cs), 1);
        chk("t4_we", 32'(sram_we), 0);
        chk("t4_addr", 32'(sram_addr), 3);
        rd_req = 1'b0;
        cyc1();
        chk("t4_ack_pulse", 32'(rd_ack), 0);
        cyc1();
        chk("t4_valid_early", 32'(rd_valid), 0);
        cyc1();
        chk("t4_valid", 32'(rd_valid), 1);
        chk("t4_data", rd_data, 32'hDEAD_BEEF);
        cyc1();
        chk("t4_valid_pulse", 32'(rd_valid), 0);

        // ---- read while FIFO full ----
        cyc1();
        i = 0; b = 0;
        while (b < 50) begin
            ram_wr_req = 1'b1; ram_waddr = 20'd20 + 20'(i); ram_wdata = 32'h2000_0000 + 32'(i);
            #1;
            if (!ram_wr_ack) break;
            cyc1(); i++; b++;
        end
        chk("t5_full", 32'(fifo_lvl), 4);
        ram_wr_req = 1'b0; rd_req = 1'b1; rd_addr = 20'd7;
        ns = wlog_addr.size();
        b = 0;
        do begin cyc1(); b++; end while (!rd_ack && b < 20);
        chk("t5_rd_ack", 32'(rd_ack), 1);
        rd_req = 1'b0;
        chk("t5_one_drain", 32'(wlog_addr.size() - ns), 1);
        chk("t5_lvl3", 32'(fifo_lvl), 3);
        b = 0;
        while (!rd_valid && b < 20) begin cyc1(); b++; end
        chk("t5_rd_valid", 32'(rd_valid), 1);
        chk("t5_rd_data", rd_data, 32'h1000_0007);
        chk("t5_no_wr_during_rd", 32'(wlog_addr.size() - ns), 1);
        b = 0;
        while (wlog_addr.size() - ns < 4 && b < 50) begin cyc1(); b++; end
        chk("t5_rest_n", 32'(wlog_addr.size() - ns), 4);
        if (wlog_addr.size() - ns == 4)
            for (int k = 0; k < 4; k++)
                chk("t5_rest_addr", 32'(wlog_addr[ns+k]), 32'(20 + i - 4 + k));
        repeat (4) cyc1();
        chk("t5_lvl0", 32'(fifo_lvl), 0);

        // ---- reset mid-write ----
        ram_wr_req = 1'b1; ram_waddr = 20'd40; ram_wdata = 32'h4000_0040;
        cyc1(); ram_waddr = 20'd41; ram_wdata = 32'h4000_0041;
        cyc1(); ram_waddr = 20'd42; ram_wdata = 32'h4000_0042;
        cyc1(); ram_wr_req = 1'b0;
        chk("t6_in_wr", 32'(sram_cs), 1);
        chk("t6_queued", 32'(fifo_lvl), 2);
        rst = 1'b1;
        #1;
        chk("t6_ack_rst", 32'(ram_wr_ack), 0);
        nr = wlog_addr.size();
        cyc1();
        chk("t6_cs", 32'(sram_cs), 0);
        chk("t6_lvl", 32'(fifo_lvl), 0);
        chk("t6_wr_cnt", 32'(wr_cnt), 0);
        chk("t6_ack_hold", 32'(ram_wr_ack), 0);
        rst = 1'b0;
        repeat (4) cyc1();
        chk("t6_discarded", 32'(wlog_addr.size() - nr), 0);
        ram_wr_req = 1'b1; ram_waddr = 20'd50; ram_wdata = 32'h5050_5050;
        cyc1(); ram_wr_req = 1'b0;
        b = 0;
        while (wr_cnt != 20'd1 && b < 20) begin cyc1(); b++; end
        chk("t6_fresh_cnt", 32'(wr_cnt), 1);
        chk("t6_fresh_n", 32'(wlog_addr.size() - nr), 1);
        chk("t6_fresh_addr", 32'(wlog_addr[wlog_addr.size()-1]), 50);
        chk("t6_fresh_data", wlog_data[wlog_data.size()-1], 32'h5050_5050);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
